// File: rtl/pc_gen_pkg.sv
// Shared definitions for the IF-stage program-counter generator: FSM encoding,
// default reset vector / step and the instruction address bus width used by IF/ID.
package pc_gen_pkg;

    localparam int INST_ADDR_BUS_W = 32;

    localparam logic [INST_ADDR_BUS_W-1:0] PC_DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [INST_ADDR_BUS_W-1:0] PC_DEFAULT_STEP      = 32'd4;

    typedef enum logic {
        PC_ST_OFF = 1'b0,
        PC_ST_RUN = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_gen_next_sel.sv
// Combinational next-PC priority mux: trap > branch > hold (stall/back-pressure) > step.
// With PC_MISALIGN_CHECK_EN defined, misaligned branch targets are suppressed and flagged.
module pc_next_sel
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W = INST_ADDR_BUS_W,
    parameter logic [ADDR_W-1:0] STEP   = ADDR_W'(PC_DEFAULT_STEP)
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              stall_i,
    input  logic              ready_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              trap_i,
    input  logic [ADDR_W-1:0] trap_vec_i,
    output logic [ADDR_W-1:0] pc_next_o,
    output logic              redirect_o
`ifdef PC_MISALIGN_CHECK_EN
    ,
    output logic              misalign_o
`endif
);

    logic br_ok;

`ifdef PC_MISALIGN_CHECK_EN
    // A misaligned branch only matters when no trap outranks it.
    assign misalign_o = br_taken_i && !trap_i && (br_target_i[1:0] != 2'b00);
    assign br_ok      = br_taken_i && !misalign_o;
`else
    assign br_ok      = br_taken_i;
`endif

    always_comb begin
        pc_next_o  = pc_i;
        redirect_o = 1'b0;
        if (trap_i) begin
            pc_next_o  = trap_vec_i;
            redirect_o = 1'b1;
        end else if (br_ok) begin
            pc_next_o  = br_target_i;
            redirect_o = 1'b1;
        end else if (!stall_i && ready_i) begin
            pc_next_o  = pc_i + STEP;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program-counter generator with OFF/RUN fetch-enable FSM, redirects and flush pulse.
// Optional misaligned-branch detection (misalign_o) is built when PC_MISALIGN_CHECK_EN is defined.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W    = INST_ADDR_BUS_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_DEFAULT_RESET_VEC),
    parameter logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_DEFAULT_STEP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              ready_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              trap_i,
    input  logic [ADDR_W-1:0] trap_vec_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic              flush_o
`ifdef PC_MISALIGN_CHECK_EN
    ,
    output logic              misalign_o
`endif
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] sel_pc;
    logic              sel_redirect;
`ifdef PC_MISALIGN_CHECK_EN
    logic              sel_misalign;
    logic              misalign_q, misalign_d;
`endif

    pc_next_sel #(
        .ADDR_W (ADDR_W),
        .STEP   (STEP)
    ) u_next_sel (
        .pc_i        (pc_q),
        .stall_i     (stall_i),
        .ready_i     (ready_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .trap_i      (trap_i),
        .trap_vec_i  (trap_vec_i),
        .pc_next_o   (sel_pc),
        .redirect_o  (sel_redirect)
`ifdef PC_MISALIGN_CHECK_EN
        ,
        .misalign_o  (sel_misalign)
`endif
    );

    // OFF->RUN presents RESET_VEC once more with ce high; requests seen in OFF are dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ce_d    = ce_q;
        flush_d = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
        misalign_d = 1'b0;
`endif
        case (state_q)
            PC_ST_OFF: begin
                state_d = PC_ST_RUN;
                ce_d    = 1'b1;
                pc_d    = RESET_VEC;
            end
            PC_ST_RUN: begin
                ce_d    = 1'b1;
                pc_d    = sel_pc;
                flush_d = sel_redirect;
`ifdef PC_MISALIGN_CHECK_EN
                misalign_d = sel_misalign;
`endif
            end
            default: begin
                state_d = PC_ST_OFF;
                ce_d    = 1'b0;
                pc_d    = RESET_VEC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PC_ST_OFF;
            pc_q    <= RESET_VEC;
            ce_q    <= 1'b0;
            flush_q <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ce_q    <= ce_d;
            flush_q <= flush_d;
`ifdef PC_MISALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    assign pc_o    = pc_q;
    assign ce_o    = ce_q;
    assign flush_o = flush_q;
`ifdef PC_MISALIGN_CHECK_EN
    assign misalign_o = misalign_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a 32-bit and an 8-bit instance share control inputs and
// are compared every cycle against a behavioural model; PC_MISALIGN_CHECK_EN is honoured.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, ready_i, br_taken_i, trap_i;
    logic [31:0] br_target_i, trap_vec_i;

    logic [31:0] pc_a;
    logic        ce_a, flush_a;
    logic [7:0]  pc_b;
    logic        ce_b, flush_b;
`ifdef PC_MISALIGN_CHECK_EN
    logic        mis_a, mis_b;
`endif

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    bit              m_run;
    longint unsigned m_pc_a, m_pc_b;
    bit              m_flush;
    bit              m_mis;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .RESET_VEC(32'h1000), .STEP(32'd4)) dut_a (
        .clk(clk), .rst(rst), .stall_i(stall_i), .ready_i(ready_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .trap_i(trap_i), .trap_vec_i(trap_vec_i),
        .pc_o(pc_a), .ce_o(ce_a), .flush_o(flush_a)
`ifdef PC_MISALIGN_CHECK_EN
        , .misalign_o(mis_a)
`endif
    );

    pc_gen #(.ADDR_W(8), .RESET_VEC(8'hF0), .STEP(8'd4)) dut_b (
        .clk(clk), .rst(rst), .stall_i(stall_i), .ready_i(ready_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i[7:0]),
        .trap_i(trap_i), .trap_vec_i(trap_vec_i[7:0]),
        .pc_o(pc_b), .ce_o(ce_b), .flush_o(flush_b)
`ifdef PC_MISALIGN_CHECK_EN
        , .misalign_o(mis_b)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Apply the model's rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        bit misaligned;
        misaligned = 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
        misaligned = br_taken_i && !trap_i && (br_target_i[1:0] != 2'b00);
`endif
        m_flush = 1'b0;
        m_mis   = 1'b0;
        if (rst) begin
            m_run  = 1'b0;
            m_pc_a = 64'h1000;
            m_pc_b = 64'hF0;
        end else if (!m_run) begin
            m_run  = 1'b1;
            m_pc_a = 64'h1000;
            m_pc_b = 64'hF0;
        end else if (trap_i) begin
            m_pc_a  = trap_vec_i;
            m_pc_b  = trap_vec_i % 256;
            m_flush = 1'b1;
        end else if (br_taken_i && !misaligned) begin
            m_pc_a  = br_target_i;
            m_pc_b  = br_target_i % 256;
            m_flush = 1'b1;
        end else begin
            m_mis = misaligned;
            if (!stall_i && ready_i) begin
                m_pc_a = (m_pc_a + 4) % (64'd1 << 32);
                m_pc_b = (m_pc_b + 4) % 256;
            end
        end
    endtask

    task automatic compare_model();
        chk("pc_a",    {32'b0, pc_a}, m_pc_a);
        chk("ce_a",    {63'b0, ce_a}, {63'b0, m_run});
        chk("flush_a", {63'b0, flush_a}, {63'b0, m_flush});
        chk("pc_b",    {56'b0, pc_b}, m_pc_b);
        chk("ce_b",    {63'b0, ce_b}, {63'b0, m_run});
        chk("flush_b", {63'b0, flush_b}, {63'b0, m_flush});
`ifdef PC_MISALIGN_CHECK_EN
        chk("mis_a",   {63'b0, mis_a}, {63'b0, m_mis});
        chk("mis_b",   {63'b0, mis_b}, {63'b0, m_mis});
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        stall_i = 1'b0; ready_i = 1'b1; br_taken_i = 1'b0; trap_i = 1'b0;
        br_target_i = 32'h0; trap_vec_i = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_run = 1'b0; m_pc_a = 64'h1000; m_pc_b = 64'hF0; m_flush = 1'b0; m_mis = 1'b0;

        // reset held three cycles, with a redirect request that must be ignored
        br_taken_i = 1'b1; br_target_i = 32'h5000;
        repeat (3) tick();
        chk("rst_pc_a", {32'b0, pc_a}, 64'h1000);
        chk("rst_ce_a", {63'b0, ce_a}, 64'h0);
        chk("rst_flush_a", {63'b0, flush_a}, 64'h0);
        idle_inputs();

        // release: RESET_VEC presented with ce high, then sequential steps
        rst = 1'b0;
        tick();
        chk("run0_pc_a", {32'b0, pc_a}, 64'h1000);
        chk("run0_ce_a", {63'b0, ce_a}, 64'h1);
        tick();
        chk("run1_pc_a", {32'b0, pc_a}, 64'h1004);
        tick();
        chk("run2_pc_a", {32'b0, pc_a}, 64'h1008);

        // stall two cycles then back-pressure one cycle
        stall_i = 1'b1;
        tick(); tick();
        stall_i = 1'b0; ready_i = 1'b0;
        tick();
        chk("hold_pc_a", {32'b0, pc_a}, 64'h1008);
        ready_i = 1'b1;
        tick();
        chk("resume_pc_a", {32'b0, pc_a}, 64'h100C);

        // branch overrides stall
        stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h2000;
        tick();
        chk("br_pc_a", {32'b0, pc_a}, 64'h2000);
        chk("br_flush_a", {63'b0, flush_a}, 64'h1);
        idle_inputs();
        tick();
        chk("br_next_pc_a", {32'b0, pc_a}, 64'h2004);
        chk("br_flush_end_a", {63'b0, flush_a}, 64'h0);

        // trap beats simultaneous branch
        trap_i = 1'b1; trap_vec_i = 32'h80; br_taken_i = 1'b1; br_target_i = 32'h3000;
        tick();
        chk("trap_pc_a", {32'b0, pc_a}, 64'h80);
        chk("trap_flush_a", {63'b0, flush_a}, 64'h1);
        idle_inputs();
        tick();
        chk("trap_flush_end_a", {63'b0, flush_a}, 64'h0);

        // redirect under back-pressure holds the target until ready
        ready_i = 1'b0; br_taken_i = 1'b1; br_target_i = 32'h10FC;
        tick();
        br_taken_i = 1'b0;
        tick();
        chk("br_hold_pc_b", {56'b0, pc_b}, 64'hFC);
        ready_i = 1'b1;
        tick();
        chk("wrap_pc_b", {56'b0, pc_b}, 64'h00);
        chk("wrap_pc_a", {32'b0, pc_a}, 64'h1100);

        // back-to-back redirects give consecutive flushes
        br_taken_i = 1'b1; br_target_i = 32'h4000;
        tick();
        br_target_i = 32'h4100;
        tick();
        chk("b2b_flush_a", {63'b0, flush_a}, 64'h1);
        chk("b2b_pc_a", {32'b0, pc_a}, 64'h4100);

        // low target bits: loaded as-is, or suppressed and flagged when checking is built in
        br_target_i = 32'h2002;
        tick();
`ifdef PC_MISALIGN_CHECK_EN
        chk("mis_pc_a", {32'b0, pc_a}, 64'h4104);
        chk("mis_flag_a", {63'b0, mis_a}, 64'h1);
        chk("mis_flush_a", {63'b0, flush_a}, 64'h0);
`else
        chk("unal_pc_a", {32'b0, pc_a}, 64'h2002);
        chk("unal_flush_a", {63'b0, flush_a}, 64'h1);
`endif
        idle_inputs();
        tick();

        // mid-run reset with a pending branch
        rst = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h7000;
        tick();
        chk("midrst_pc_a", {32'b0, pc_a}, 64'h1000);
        chk("midrst_ce_a", {63'b0, ce_a}, 64'h0);
        chk("midrst_flush_a", {63'b0, flush_a}, 64'h0);
        chk("midrst_pc_b", {56'b0, pc_b}, 64'hF0);
        rst = 1'b0;
        tick();
        chk("midrst_run_pc_a", {32'b0, pc_a}, 64'h1000);
        idle_inputs();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 99) < 2);
            stall_i     = ($urandom_range(0, 99) < 25);
            ready_i     = ($urandom_range(0, 99) < 75);
            br_taken_i  = ($urandom_range(0, 99) < 15);
            trap_i      = ($urandom_range(0, 99) < 8);
            br_target_i = $urandom();
            if ($urandom_range(0, 3) != 0) br_target_i[1:0] = 2'b00;
            trap_vec_i  = $urandom();
            if ($urandom_range(0, 9) == 0) begin
                br_target_i = 32'hFFFF_FFFC;
                br_taken_i  = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the IF stage; successor to the fixed-width free-running PC register.
- Adds a configurable reset vector and step, stall/back-pressure hold, branch/jump redirect, trap redirect, a flush pulse to IF, and a fetch-enable state machine.
- Sits between the pipeline control logic (hazard unit, EX branch resolution, exception unit) and instruction memory / IF.

Parameters:
- ADDR_W, 32, width of PC and all address ports.
- RESET_VEC, 0, PC value presented in the first enabled cycle after reset.
- STEP, 4, sequential increment in bytes; must be nonzero and less than 2^ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  pipeline stall from the hazard unit; holds the PC.
- ready_i  in  1  IF/instruction memory accepts the current pc_o.
- br_taken_i  in  1  branch/jump redirect request from EX.
- br_target_i  in  ADDR_W  branch/jump target address.
- trap_i  in  1  exception/interrupt redirect request.
- trap_vec_i  in  ADDR_W  trap handler address.
- pc_o  out  ADDR_W  current fetch address.
- ce_o  out  1  fetch enable to instruction memory.
- flush_o  out  1  one-cycle pulse telling IF to discard the in-flight instruction.

Behaviour:
- States: OFF and RUN.
- OFF:
  - ce_o=0, pc_o=RESET_VEC, flush_o=0.
  - Entered on any clock edge with rst=1, from either state; reset mid-operation discards pending redirects.
- OFF -> RUN: on the first edge with rst=0.
  - From that cycle on, ce_o=1 and pc_o=RESET_VEC.
  - No increment and no redirect is taken on this transition edge. Redirect inputs sampled while in OFF are ignored.
- RUN next-PC selection, evaluated at each edge with rst=0, highest priority first:
  - trap_i=1: pc <= trap_vec_i; flush_o=1 next cycle.
  - br_taken_i=1: pc <= br_target_i; flush_o=1 next cycle.
  - stall_i=1 or ready_i=0: pc holds; flush_o=0.
  - Otherwise: pc <= pc + STEP, modulo 2^ADDR_W.
- Redirects override stall and back-pressure. A target is loaded even when ready_i=0; the new pc_o is then held until ready_i=1.
- flush_o is registered: exactly one cycle high following each redirect edge. Back-to-back redirects give consecutive flush cycles.
- Simultaneous trap_i and br_taken_i: trap wins; the branch is dropped and not buffered.
- Wrap-around: from pc = 2^ADDR_W - STEP, the next sequential pc is 0, with no flag.
- Latency: one cycle from any request input to the corresponding pc_o change. pc_o and ce_o are driven directly from flops.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_o (1 bit, registered, reset 0).
  - If br_taken_i=1 and trap_i=0 and br_target_i[1:0]!=0, the redirect is suppressed and the cycle behaves as if br_taken_i=0.
  - misalign_o pulses high for one cycle and flush_o stays 0. The exception unit is expected to issue trap_i afterwards.
  - trap_vec_i is not checked.
- Undefined:
  - Port is absent.
  - br_target_i is loaded unmodified, including its low bits.

Decomposition:
- Shared package holds:
  - state encoding constants PC_ST_OFF=0 and PC_ST_RUN=1;
  - the default reset vector and step;
  - the InstAddrBus width constant shared with IF/ID.
- One sub-module is natural: pc_next_sel, a purely combinational priority mux producing next-pc and a redirect flag. pc_gen keeps the state flop, the pc register and the flush/misalign registers.

Test Plan:
- Reset release (ADDR_W=32, RESET_VEC=0x1000, STEP=4): hold rst 3 cycles, then release -> ce_o=0 and pc_o=0x1000 during reset; first RUN cycle pc_o=0x1000 with ce_o=1; then 0x1004, 0x1008.
- Stall and back-pressure: stall_i=1 for 2 cycles at pc 0x1008, then ready_i=0 for 1 cycle -> pc_o stays 0x1008 for 3 cycles, then 0x100C.
- Branch: br_taken_i=1 with target 0x2000 at pc 0x100C while stall_i=1 -> next pc_o=0x2000 and flush_o=1 for exactly one cycle; then 0x2004.
- Simultaneous trap and branch: trap_vec_i=0x80, br_target_i=0x3000 -> pc_o=0x80 and a single flush pulse.
- Wrap and mid-run reset: with ADDR_W=8 and STEP=4, pc 0xFC goes to 0x00; asserting rst together with br_taken_i -> OFF state, pc_o=RESET_VEC, no flush.
- With PC_MISALIGN_CHECK_EN: target 0x2002 -> pc increments normally, misalign_o=1 for one cycle, flush_o=0.
